hl_io_bank_ctrl: RTL
====================

Name: hl_io_bank_ctrl

Overview:
- Parametrised, clocked controller for an N-slice HL pad bank; the next generation of the fixed 8-slice south IO hookup.
- Holds per-slice pad configuration (drive, slew, pulls, push-pull, input enable) behind a valid/ready write port.
- Sequences pad power-up, registers output data and enables, synchronises pad inputs, and raises sticky rising-edge interrupts.
- Sits between the SoC GPIO/MMIO logic and the pad macro pins.

Parameters:
- N_SLICES, 8, number of pad slices; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; minimum 2.
- PWRUP_CYCLES, 16, cycles spent in PWRUP with pads hi-Z and power-up pulls on; 0 is legal.
- RESET_CFG, 8'h61, per-slice config after reset: drv=1, pd=1, ppen=1, ie=0.

Ports:
- clock  in  1  bank clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid; high only in RUN.
- cfg_addr  in  5  target slice index.
- cfg_wdata  in  8  config word: [2:0] drv, [3] slew, [4] pull-up, [5] pull-down, [6] ppen, [7] ie.
- cfg_err  out  1  one-cycle pulse on an accepted write with cfg_addr >= N_SLICES.
- gpio_out  in  N_SLICES  output data, active-high.
- gpio_oe  in  N_SLICES  output enable, active-high.
- gpio_in  out  N_SLICES  synchronised pad input; forced 0 when ie=0.
- irq_en  in  N_SLICES  per-slice rising-edge interrupt enable.
- irq_clear  in  N_SLICES  per-slice clear of the pending bit.
- irq_pending  out  N_SLICES  sticky rising-edge flags.
- irq  out  1  OR of irq_pending.
- pwrup_done  out  1  high in RUN.
- pad_dq, pad_enq, pad_enabq, pad_puq, pad_pd, pad_ppen, pad_prg_slew, pad_drv0, pad_drv1, pad_drv2, pad_pwrup_pull_en, pad_pwrupzhl  out  N_SLICES each  pad macro controls; the "q" suffix means active-low.
- pad_outi  in  N_SLICES  raw pad receiver outputs, asynchronous.

Behaviour:
- All outputs are registered. Only irq is derived combinationally from registered bits.
- Reset values (reset_n=0 at a clock edge):
  - cfg regs = RESET_CFG; output data regs = 0, so pad_dq=1.
  - pad_enq=1, pad_enabq=1, pad_pwrupzhl=1, pad_pwrup_pull_en=1.
  - sync chains = 0, irq_pending = 0, cfg_ready=0, cfg_err=0, pwrup_done=0.
  - State = PWRUP, counter = 0.
- FSM PWRUP:
  - Counter increments each cycle; at count == PWRUP_CYCLES-1 go to RUN.
  - With PWRUP_CYCLES=0, go to RUN on the first cycle after reset releases.
  - pad_enq and pad_enabq are forced 1; pad_pwrupzhl=1 and pad_pwrup_pull_en=1; gpio_in held at 0.
- FSM RUN:
  - pad_pwrupzhl=0, pad_pwrup_pull_en=0, pwrup_done=1, cfg_ready=1.
  - RUN is left only by reset. A reset in the middle of RUN restores every reset value and reruns PWRUP.
- Config write:
  - A handshake at edge k updates cfg[cfg_addr]; the pad pins reflect it after edge k+1.
  - Only one write per cycle; cfg_ready stays high in RUN, so there is no back-pressure.
  - Out-of-range address: the write is dropped and cfg_err pulses for one cycle.
- Config decode, per slice:
  - drv0/1/2 = drv[0]/[1]/[2]; prg_slew = slew; ppen = ppen.
  - pad_puq = ~pu; pad_pd = pd. If pu and pd are both 1, neither pull is applied: puq=1, pd=0.
  - pad_enabq = ~ie in RUN.
- Output path: pad_dq = ~gpio_out and pad_enq = ~gpio_oe, each with one cycle of latency, in RUN.
- Input path:
  - pad_outi passes through SYNC_STAGES flops; gpio_in = sync & ie.
  - Input latency is SYNC_STAGES cycles.
- Interrupts:
  - A rising edge is detected when the last sync stage is 1, the previous sampled value was 0, ie=1, and irq_en=1.
  - A detected edge sets irq_pending on the next edge; irq_clear clears it.
  - Set and clear in the same cycle: set wins.
  - Edge detection is inactive in PWRUP.

Decomposition:
- Package hl_io_pkg holds:
  - cfg bit-position localparams.
  - RESET_CFG default.
  - FSM state enum {PWRUP, RUN}.
  - the cfg_t struct.
- Sub-module hl_io_slice_ctrl holds one slice: cfg register, decode, output regs, synchroniser, edge detect, and pending bit. It is instantiated N_SLICES times in a generate loop.
- The top level holds the FSM, counter, and address decode.

Test Plan:
- Reset, PWRUP_CYCLES=16 -> pad_pwrupzhl=all-1 and cfg_ready=0 for 16 cycles; pwrup_done=1 and pwrupzhl=0 from cycle 17; pad_pd=all-1, pad_drv0=all-1.
- Write addr 3 data 8'h9F (drv=7, slew=1, pu=1, ie=1) -> next cycle pad_drv0/1/2[3]=1, prg_slew[3]=1, puq[3]=0, enabq[3]=0; other slices unchanged.
- Write data 8'h30 (pu=1, pd=1) to slice 0 -> puq[0]=1, pd[0]=0; write addr 9 -> cfg_err pulses once, no cfg changes.
- gpio_oe=8'h01, gpio_out=8'h01 in RUN -> pad_enq[0]=0, pad_dq[0]=0 one cycle later; with the same inputs during PWRUP -> pad_enq[0] stays 1.
- Slice 2 ie=1, irq_en=1; pad_outi[2] goes 0->1 -> gpio_in[2]=1 after 2 cycles and irq_pending[2]=1 the next cycle, irq=1; irq_clear asserted in the same cycle as a new edge -> pending stays 1.
- Assert reset_n=0 for one cycle in RUN with a non-default cfg -> all cfg return to 8'h61, irq_pending=0, PWRUP reruns for 16 cycles.

Source files
------------

// File: rtl/hl_io_pkg.sv
// Shared constants, types and config helpers for the HL pad bank controller.
package hl_io_pkg;

  localparam int CFG_DRV_LSB = 0;
  localparam int CFG_DRV_MSB = 2;
  localparam int CFG_SLEW    = 3;
  localparam int CFG_PU      = 4;
  localparam int CFG_PD      = 5;
  localparam int CFG_PPEN    = 6;
  localparam int CFG_IE      = 7;

  localparam logic [7:0] RESET_CFG_DEF = 8'h61;

  typedef enum logic [0:0] {
    PWRUP = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic       ie;
    logic       ppen;
    logic       pd;
    logic       pu;
    logic       slew;
    logic [2:0] drv;
  } cfg_t;

  typedef struct packed {
    logic       puq;
    logic       pd;
    logic       ppen;
    logic       slew;
    logic [2:0] drv;
  } pad_ctl_t;

  function automatic cfg_t cfg_unpack(input logic [7:0] w);
    cfg_t c;
    c.drv  = w[CFG_DRV_MSB:CFG_DRV_LSB];
    c.slew = w[CFG_SLEW];
    c.pu   = w[CFG_PU];
    c.pd   = w[CFG_PD];
    c.ppen = w[CFG_PPEN];
    c.ie   = w[CFG_IE];
    return c;
  endfunction

  // Pull-up and pull-down requested together cancel, so the pad never fights itself.
  function automatic pad_ctl_t cfg_decode(input cfg_t c);
    pad_ctl_t p;
    p.puq  = ~(c.pu & ~c.pd);
    p.pd   = c.pd & ~c.pu;
    p.ppen = c.ppen;
    p.slew = c.slew;
    p.drv  = c.drv;
    return p;
  endfunction

endpackage

// File: rtl/hl_io_slice_ctrl.sv
// One pad slice: config register and decode, output regs, input synchroniser,
// rising-edge detector and sticky interrupt flag.
module hl_io_slice_ctrl
  import hl_io_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_CFG   = RESET_CFG_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       cfg_we,
  input  logic [7:0] cfg_wdata,
  input  logic       gpio_out,
  input  logic       gpio_oe,
  input  logic       irq_en,
  input  logic       irq_clear,
  input  logic       pad_outi,
  output logic       gpio_in,
  output logic       irq_pending,
  output logic       pad_dq,
  output logic       pad_enq,
  output logic       pad_enabq,
  output logic       pad_puq,
  output logic       pad_pd,
  output logic       pad_ppen,
  output logic       pad_prg_slew,
  output logic       pad_drv0,
  output logic       pad_drv1,
  output logic       pad_drv2
);

  localparam cfg_t     RST_CFG = cfg_unpack(RESET_CFG);
  localparam pad_ctl_t RST_PAD = cfg_decode(RST_CFG);

  cfg_t                   cfg_r;
  pad_ctl_t               pad_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_s;

  assign pad_puq      = pad_r.puq;
  assign pad_pd       = pad_r.pd;
  assign pad_ppen     = pad_r.ppen;
  assign pad_prg_slew = pad_r.slew;
  assign pad_drv0     = pad_r.drv[0];
  assign pad_drv1     = pad_r.drv[1];
  assign pad_drv2     = pad_r.drv[2];

  assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r & cfg_r.ie & irq_en & run;

  // Config store; pad controls follow the stored word one cycle later.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cfg_r <= RST_CFG;
      pad_r <= RST_PAD;
    end else begin
      if (cfg_we) begin
        cfg_r <= cfg_unpack(cfg_wdata);
      end else begin
        cfg_r <= cfg_r;
      end
      pad_r <= cfg_decode(cfg_r);
    end
  end

  // Output path: pads stay hi-Z with receivers off until the bank is running.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pad_dq    <= 1'b1;
      pad_enq   <= 1'b1;
      pad_enabq <= 1'b1;
    end else if (run) begin
      pad_dq    <= ~gpio_out;
      pad_enq   <= ~gpio_oe;
      pad_enabq <= ~cfg_r.ie;
    end else begin
      pad_dq    <= 1'b1;
      pad_enq   <= 1'b1;
      pad_enabq <= 1'b1;
    end
  end

  // Input path: the gated gpio_in flop sits in parallel with the last sync stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_r      <= '0;
      prev_r      <= 1'b0;
      gpio_in     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], pad_outi};
      prev_r  <= sync_r[SYNC_STAGES-1];
      gpio_in <= sync_r[SYNC_STAGES-2] & cfg_r.ie & run;
      if (edge_s) begin
        irq_pending <= 1'b1;
      end else if (irq_clear) begin
        irq_pending <= 1'b0;
      end else begin
        irq_pending <= irq_pending;
      end
    end
  end

endmodule

// File: rtl/hl_io_bank_ctrl.sv
// N-slice HL pad bank controller: power-up sequencing FSM, config address
// decode and per-slice instances.
module hl_io_bank_ctrl
  import hl_io_pkg::*;
#(
  parameter int         N_SLICES     = 8,
  parameter int         SYNC_STAGES  = 2,
  parameter int         PWRUP_CYCLES = 16,
  parameter logic [7:0] RESET_CFG    = RESET_CFG_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [4:0]          cfg_addr,
  input  logic [7:0]          cfg_wdata,
  output logic                cfg_err,
  input  logic [N_SLICES-1:0] gpio_out,
  input  logic [N_SLICES-1:0] gpio_oe,
  output logic [N_SLICES-1:0] gpio_in,
  input  logic [N_SLICES-1:0] irq_en,
  input  logic [N_SLICES-1:0] irq_clear,
  output logic [N_SLICES-1:0] irq_pending,
  output logic                irq,
  output logic                pwrup_done,
  output logic [N_SLICES-1:0] pad_dq,
  output logic [N_SLICES-1:0] pad_enq,
  output logic [N_SLICES-1:0] pad_enabq,
  output logic [N_SLICES-1:0] pad_puq,
  output logic [N_SLICES-1:0] pad_pd,
  output logic [N_SLICES-1:0] pad_ppen,
  output logic [N_SLICES-1:0] pad_prg_slew,
  output logic [N_SLICES-1:0] pad_drv0,
  output logic [N_SLICES-1:0] pad_drv1,
  output logic [N_SLICES-1:0] pad_drv2,
  output logic [N_SLICES-1:0] pad_pwrup_pull_en,
  output logic [N_SLICES-1:0] pad_pwrupzhl,
  input  logic [N_SLICES-1:0] pad_outi
);

  localparam int CNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  // A zero-length power-up collapses onto count 0, giving one PWRUP cycle after reset.
  localparam int LAST  = (PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0;

  state_t              state_r;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt_r;
  logic                run_s;
  logic [N_SLICES-1:0] we_s;

  // State and power-up counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= PWRUP;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      if (state_r == PWRUP) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next state: RUN is only left through reset.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      PWRUP: begin
        if (cnt_r == CNT_W'(LAST)) begin
          state_nx = RUN;
        end else begin
          state_nx = PWRUP;
        end
      end
      RUN:     state_nx = RUN;
      default: state_nx = PWRUP;
    endcase
  end

  // Moore outputs decoded straight from the state flop.
  always_comb begin
    run_s             = 1'b0;
    case (state_r)
      RUN:     run_s = 1'b1;
      PWRUP:   run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
    pwrup_done        = run_s;
    cfg_ready         = run_s;
    pad_pwrupzhl      = {N_SLICES{~run_s}};
    pad_pwrup_pull_en = {N_SLICES{~run_s}};
  end

  // Address decode for accepted writes.
  always_comb begin
    we_s = '0;
    for (int i = 0; i < N_SLICES; i++) begin
      we_s[i] = cfg_valid & run_s & (int'(cfg_addr) == i);
    end
  end

  // Error pulse for an accepted write outside the bank.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_valid & run_s & (int'(cfg_addr) >= N_SLICES);
    end
  end

  assign irq = |irq_pending;

  for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
    hl_io_slice_ctrl #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_CFG  (RESET_CFG)
    ) u_slice (
      .clock       (clock),
      .reset_n     (reset_n),
      .run         (run_s),
      .cfg_we      (we_s[g]),
      .cfg_wdata   (cfg_wdata),
      .gpio_out    (gpio_out[g]),
      .gpio_oe     (gpio_oe[g]),
      .irq_en      (irq_en[g]),
      .irq_clear   (irq_clear[g]),
      .pad_outi    (pad_outi[g]),
      .gpio_in     (gpio_in[g]),
      .irq_pending (irq_pending[g]),
      .pad_dq      (pad_dq[g]),
      .pad_enq     (pad_enq[g]),
      .pad_enabq   (pad_enabq[g]),
      .pad_puq     (pad_puq[g]),
      .pad_pd      (pad_pd[g]),
      .pad_ppen    (pad_ppen[g]),
      .pad_prg_slew(pad_prg_slew[g]),
      .pad_drv0    (pad_drv0[g]),
      .pad_drv1    (pad_drv1[g]),
      .pad_drv2    (pad_drv2[g])
    );
  end

endmodule
